// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: RV32M multiply/divide unit, 32-step restoring divider and shift-add multiplier.
// Define MULDIV_FAST_MUL_EN to run MUL/MULH/MULHSU/MULHU as one single-cycle signed multiply.
module muldiv_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_op,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  input  logic [4:0]  in_rd,
  input  logic        kill,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        busy
);

  // Op encoding: {2'b11, div, sel[1:0]}.
  //   mul sel: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
  //   div sel: 00 DIV, 01 DIVU, 10 REM,    11 REMU
  localparam logic [1:0] AluMulPrepend = 2'b11;

  // Handshakes: a request transfers on a rising edge where in_valid & in_ready & !kill;
  // a result transfers on a rising edge where out_valid & out_ready. kill wins over both.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [2:0]  op_q;
  logic [4:0]  rd_q;
  logic [4:0]  count;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] dvs;
  logic        neg_q;
  logic        neg_r;
  logic        fast_q;
`ifdef MULDIV_FAST_MUL_EN
  logic        sext_a;
  logic        sext_b;
`endif

  // Request decode
  logic        in_is_md;
  logic        in_is_div;
  logic        in_a_signed;
  logic        in_b_signed;
  logic        in_a_neg;
  logic        in_b_neg;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic        div_zero;
  logic        div_ovf;
  logic        in_special;
  logic [31:0] special_res;
  logic        in_fast;

  always_comb begin
    in_is_md    = (in_op[4:3] == AluMulPrepend);
    in_is_div   = in_op[2];
    in_a_signed = in_is_div ? ~in_op[0] : (in_op[1] ^ in_op[0]);
    in_b_signed = in_is_div ? ~in_op[0] : (in_op[1:0] == 2'b01);
    in_a_neg    = in_a_signed & in_rs1[31];
    in_b_neg    = in_b_signed & in_rs2[31];
    mag_a       = in_a_neg ? (~in_rs1 + 32'd1) : in_rs1;
    mag_b       = in_b_neg ? (~in_rs2 + 32'd1) : in_rs2;
    div_zero    = in_is_md & in_is_div & (in_rs2 == 32'd0);
    div_ovf     = in_is_md & in_is_div & ~in_op[0] &
                  (in_rs1 == 32'h8000_0000) & (in_rs2 == 32'hFFFF_FFFF);
    in_special  = ~in_is_md | div_zero | div_ovf;
    special_res = 32'd0;
    if (!in_is_md) begin
      special_res = 32'd0;
    end else if (div_zero) begin
      special_res = in_op[1] ? in_rs1 : 32'hFFFF_FFFF;
    end else if (div_ovf) begin
      special_res = in_op[1] ? 32'd0 : 32'h8000_0000;
    end
`ifdef MULDIV_FAST_MUL_EN
    in_fast = in_is_md & ~in_is_div;
`else
    in_fast = 1'b0;
`endif
  end

  // One iteration step of the shared hi/lo datapath
  logic [32:0] rem_sh;
  logic [32:0] diff;
  logic [32:0] sum;
  logic [31:0] step_hi;
  logic [31:0] step_lo;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;
  logic [63:0] prod;
  logic [63:0] prod_fix;
  logic [31:0] calc_res;
`ifdef MULDIV_FAST_MUL_EN
  logic signed [63:0] fast_a;
  logic signed [63:0] fast_b;
  logic signed [63:0] fast_p;
`endif

  always_comb begin
    rem_sh = {hi, lo[31]};
    diff   = rem_sh - {1'b0, dvs};
    sum    = {1'b0, hi} + (lo[0] ? {1'b0, dvs} : 33'd0);
    if (op_q[2]) begin
      // Restoring divide: lo shifts the dividend out and the quotient in.
      step_hi = diff[32] ? rem_sh[31:0] : diff[31:0];
      step_lo = {lo[30:0], ~diff[32]};
    end else begin
      step_hi = sum[32:1];
      step_lo = {sum[0], lo[31:1]};
    end
    quot_fix = neg_q ? (~step_lo + 32'd1) : step_lo;
    rem_fix  = neg_r ? (~step_hi + 32'd1) : step_hi;
    prod     = {step_hi, step_lo};
    prod_fix = neg_q ? (~prod + 64'd1) : prod;
    if (op_q[2]) begin
      calc_res = op_q[1] ? rem_fix : quot_fix;
    end else begin
      calc_res = (op_q[1:0] == 2'b00) ? prod_fix[31:0] : prod_fix[63:32];
    end
`ifdef MULDIV_FAST_MUL_EN
    // Sign-extended 64-bit operands: equivalent to a 33x33 signed product mod 2^64.
    fast_a = {{32{sext_a & lo[31]}}, lo};
    fast_b = {{32{sext_b & dvs[31]}}, dvs};
    fast_p = fast_a * fast_b;
    if (fast_q) begin
      calc_res = (op_q[1:0] == 2'b00) ? fast_p[31:0] : fast_p[63:32];
    end
`endif
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_result <= 32'd0;
      out_rd     <= 5'd0;
      op_q       <= 3'd0;
      rd_q       <= 5'd0;
      count      <= 5'd0;
      hi         <= 32'd0;
      lo         <= 32'd0;
      dvs        <= 32'd0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      fast_q     <= 1'b0;
`ifdef MULDIV_FAST_MUL_EN
      sext_a     <= 1'b0;
      sext_b     <= 1'b0;
`endif
    end else if (kill) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q   <= in_op[2:0];
            rd_q   <= in_rd;
            count  <= 5'd31;
            neg_q  <= in_a_neg ^ in_b_neg;
            neg_r  <= in_a_neg;
            hi     <= 32'd0;
            lo     <= in_fast ? in_rs1 : mag_a;
            dvs    <= in_fast ? in_rs2 : mag_b;
            fast_q <= in_fast;
`ifdef MULDIV_FAST_MUL_EN
            sext_a <= in_a_signed;
            sext_b <= in_b_signed;
`endif
            if (in_special) begin
              state      <= DONE;
              out_valid  <= 1'b1;
              out_result <= special_res;
              out_rd     <= in_rd;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          hi    <= step_hi;
          lo    <= step_lo;
          count <= count - 5'd1;
          if ((count == 5'd0) || fast_q) begin
            state      <= DONE;
            out_valid  <= 1'b1;
            out_result <= calc_res;
            out_rd     <= rd_q;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed vectors against a transaction-level model of muldiv_ctrl.
// Honours MULDIV_FAST_MUL_EN for the expected multiply latency.
`timescale 1ns/1ps
module tb_muldiv_ctrl;

  localparam logic [4:0] OP_MUL    = 5'b11000;
  localparam logic [4:0] OP_MULH   = 5'b11001;
  localparam logic [4:0] OP_MULHSU = 5'b11010;
  localparam logic [4:0] OP_MULHU  = 5'b11011;
  localparam logic [4:0] OP_DIV    = 5'b11100;
  localparam logic [4:0] OP_DIVU   = 5'b11101;
  localparam logic [4:0] OP_REM    = 5'b11110;
  localparam logic [4:0] OP_REMU   = 5'b11111;
  localparam logic [4:0] OP_ADD    = 5'b00011;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MulLat = 2;
`else
  localparam int MulLat = 33;
`endif

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_op;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [4:0]  in_rd;
  logic        kill;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        busy;

  muldiv_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_rd      (in_rd),
    .kill       (kill),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd),
    .busy       (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: architectural result from 64-bit arithmetic
  function automatic logic [31:0] model_res(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] ua;
    logic signed [63:0] ub;
    logic signed [63:0] p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = 64'sd0;
    case (op)
      OP_MUL:    begin p = sa * sb; return p[31:0];  end
      OP_MULH:   begin p = sa * sb; return p[63:32]; end
      OP_MULHSU: begin p = sa * ub; return p[63:32]; end
      OP_MULHU:  begin p = ua * ub; return p[63:32]; end
      OP_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      OP_REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      OP_DIVU: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      OP_REMU: begin
        if (b == 32'd0) return a;
        p = ua % ub; return p[31:0];
      end
      default: return 32'd0;
    endcase
  endfunction

  // Cycle (after accept) in which the result first appears
  function automatic int model_lat(input logic [4:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    case (op)
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: return MulLat;
      OP_DIVU, OP_REMU: return (b == 32'd0) ? 1 : 33;
      OP_DIV, OP_REM: begin
        if (b == 32'd0) return 1;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
      end
      default: return 1;
    endcase
  endfunction

  // Scoreboard: {rd, result}
  logic [36:0] exp_q[$];
  bit          m_busy = 1'b0;
  int          edge_n = 0;
  int          m_done = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      edge_n = 0;
      exp_q.delete();
    end else begin
      edge_n++;
      if (kill) begin
        m_busy = 1'b0;
        exp_q.delete();
      end else if (!m_busy) begin
        if (in_valid) begin
          m_busy = 1'b1;
          m_done = edge_n + model_lat(in_op, in_rs1, in_rs2) - 1;
          exp_q.push_back({in_rd, model_res(in_op, in_rs1, in_rs2)});
        end
      end else if ((edge_n - 1) >= m_done && out_ready) begin
        m_busy = 1'b0;
        void'(exp_q.pop_front());
      end
    end
  end

  // Compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    bit exp_v;
    exp_v = m_busy && (edge_n >= m_done);
    check("in_ready", in_ready, !m_busy);
    check("busy", busy, m_busy);
    check("out_valid", out_valid, exp_v);
    if (exp_v && exp_q.size() > 0) begin
      check("out_result", out_result, exp_q[0][31:0]);
      check("out_rd", out_rd, exp_q[0][36:32]);
    end
  end

  // Driver tasks
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = op;
    in_rs1   = a;
    in_rs2   = b;
    in_rd    = rd;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic run_vec(input string name, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp, input int exp_lat);
    int lat;
    issue(op, a, b, rd);
    wait_valid(lat);
    check({name, "_lat"}, lat, exp_lat);
    check({name, "_res"}, out_result, exp);
    check({name, "_rd"}, out_rd, rd);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          lat;
    logic [31:0] held_res;
    bit          saw_valid;
    rst_n = 1'b0; in_valid = 1'b0; in_op = 5'd0; in_rs1 = 32'd0; in_rs2 = 32'd0;
    in_rd = 5'd0; kill = 1'b0; out_ready = 1'b1;
    #2;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_rd", out_rd, 5'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_vec("divu_100_7",  OP_DIVU, 32'd100, 32'd7, 5'd1, 32'd14, 33);
    run_vec("remu_100_7",  OP_REMU, 32'd100, 32'd7, 5'd2, 32'd2, 33);
    run_vec("div_m7_2",    OP_DIV,  32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFD, 33);
    run_vec("rem_m7_2",    OP_REM,  32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFF, 33);
    run_vec("div_100_m7",  OP_DIV,  32'd100, 32'hFFFF_FFF9, 5'd5, 32'hFFFF_FFF2, 33);
    run_vec("rem_100_m7",  OP_REM,  32'd100, 32'hFFFF_FFF9, 5'd6, 32'd2, 33);
    run_vec("divu_max_1",  OP_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd7, 32'hFFFF_FFFF, 33);
    run_vec("div_ovf",     OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h8000_0000, 1);
    run_vec("rem_ovf",     OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'd0, 1);
    run_vec("divu_zero",   OP_DIVU, 32'h1234, 32'd0, 5'd10, 32'hFFFF_FFFF, 1);
    run_vec("remu_zero",   OP_REMU, 32'h1234, 32'd0, 5'd11, 32'h1234, 1);
    run_vec("div_zero",    OP_DIV,  32'd7, 32'd0, 5'd12, 32'hFFFF_FFFF, 1);
    run_vec("mul_m1",      OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 32'd1, MulLat);
    run_vec("mulh_m1",     OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd14, 32'd0, MulLat);
    run_vec("mulhu_m1",    OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd15, 32'hFFFF_FFFE, MulLat);
    run_vec("mulhsu_m1",   OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd16, 32'hFFFF_FFFF, MulLat);
    run_vec("mul_small",   OP_MUL,    32'h0001_2345, 32'h0000_0100, 5'd17, 32'h0123_4500, MulLat);
    run_vec("mulh_min",    OP_MULH,   32'h8000_0000, 32'h8000_0000, 5'd18, 32'h4000_0000, MulLat);
    run_vec("mulhsu_min",  OP_MULHSU, 32'h8000_0000, 32'h8000_0000, 5'd19, 32'hC000_0000, MulLat);
    run_vec("non_md_op",   OP_ADD,    32'd5, 32'd6, 5'd20, 32'd0, 1);

    // Result held while the consumer stalls
    out_ready = 1'b0;
    issue(OP_DIVU, 32'd100, 32'd7, 5'd21);
    wait_valid(lat);
    check("stall_lat", lat, 33);
    held_res = out_result;
    check("stall_first", held_res, 32'd14);
    repeat (5) begin
      @(negedge clk);
      check("stall_res", out_result, 32'd14);
      check("stall_rd", out_rd, 5'd21);
      check("stall_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_in_ready", in_ready, 1'b1);
    check("release_out_valid", out_valid, 1'b0);

    // kill in CALC cycle 10 overrides a pending request
    issue(OP_DIVU, 32'd1000, 32'd3, 5'd22);
    repeat (10) @(negedge clk);
    kill = 1'b1; in_valid = 1'b1; in_op = OP_MUL; in_rs1 = 32'd6; in_rs2 = 32'd7; in_rd = 5'd23;
    @(posedge clk);
    #1;
    check("kill_busy", busy, 1'b0);
    check("kill_in_ready", in_ready, 1'b1);
    check("kill_out_valid", out_valid, 1'b0);
    kill = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("after_kill_accept", busy, 1'b1);
    wait_valid(lat);
    check("after_kill_lat", lat, MulLat);
    check("after_kill_res", out_result, 32'd42);
    check("after_kill_rd", out_rd, 5'd23);
    @(posedge clk);
    #1;

    // Reset in CALC cycle 5 abandons the operation
    issue(OP_DIVU, 32'd999, 32'd10, 5'd24);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_result", out_result, 32'd0);
    check("midrst_out_rd", out_rd, 5'd0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    saw_valid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    check("midrst_no_output", saw_valid, 1'b0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have no parameters; widths: DataWidth=32, RegAddrWidth=5, AluOpWidth=5 (defs_pkg).
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 in_valid  in  1  request valid.
REQ-005 in_ready  out  1  high iff state==IDLE.
REQ-006 in_op  in  5  alu_op_t; ALU_MUL..ALU_REMU legal.
REQ-007 in_rs1, in_rs2  in  32 each  operands.
REQ-008 in_rd  in  5  destination tag, returned unchanged.
REQ-009 kill  in  1  synchronous flush.
REQ-010 out_valid  out  1  result valid.
REQ-011 out_ready  in  1  consumer accepts result.
REQ-012 out_result  out  32  result.
REQ-013 out_rd  out  5  tag of the result.
REQ-014 busy  out  1  high iff state!=IDLE.

Function
REQ-015 FSM SHALL have states IDLE, CALC, DONE; accept = in_valid & in_ready & !kill.
REQ-016 On accept, SHALL latch op, rd, operand magnitudes and result-sign flags; 5-bit counter=31.
REQ-017 Divide-by-zero (DIV/DIVU: 0xFFFFFFFF; REM/REMU: rs1) SHALL go IDLE->DONE, skipping CALC.
REQ-018 Signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF; DIV: 0x80000000, REM: 0) SHALL go IDLE->DONE.
REQ-019 Op without AluMulPrepend (2'b11) SHALL go IDLE->DONE with out_result=0.
REQ-020 CALC SHALL perform one restoring-divide or shift-add-multiply step per cycle; counter decrements; CALC->DONE after the step at counter==0.
REQ-021 Latency SHALL be: accept in cycle 0, CALC cycles 1..32, out_valid first high in cycle 33; special cases (REQ-017..019) out_valid in cycle 1.
REQ-022 Quotient SHALL be negated iff operand signs differ (signed ops); remainder takes dividend sign.
REQ-023 MUL SHALL return product[31:0]; MULH signed*signed, MULHSU signed*unsigned, MULHU unsigned*unsigned, each product[63:32].
REQ-024 Sign fix-up SHALL be applied at CALC->DONE; out_result and out_rd registered, no combinational path from inputs.
REQ-025 In DONE, out_valid=1; out_result and out_rd SHALL hold stable until out_valid & out_ready.
REQ-026 DONE->IDLE on out_ready; new request SHALL NOT be accepted in the same cycle (in_ready=0 in DONE).
REQ-027 kill SHALL force IDLE next edge from any state, clear out_valid, discard the result; kill overrides in_valid.

Reset
REQ-028 While rst_n low: state=IDLE, out_valid=0, out_result=0, out_rd=0, busy=0, in_ready=1, counter=0.
REQ-029 Reset mid-operation SHALL abandon the operation with no output.

Configuration
REQ-030 Macro MULDIV_FAST_MUL_EN.
REQ-031 Defined: MUL* SHALL use one 33x33 signed multiply in a single CALC cycle; out_valid in cycle 2; divide unchanged.
REQ-032 Undefined: MUL* SHALL use 32-cycle iterative shift-add; out_valid in cycle 33.

Verification
REQ-033 DIVU 100/7 -> 14, REMU -> 2; DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF; out_valid cycle 33.
REQ-034 DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0; DIVU 0x1234/0 -> 0xFFFFFFFF, REMU -> 0x1234; all cycle 1.
REQ-035 rs1=rs2=0xFFFFFFFF: MUL -> 1, MULH -> 0, MULHU -> 0xFFFFFFFE, MULHSU -> 0xFFFFFFFF; cycle 33 (cycle 2 with MULDIV_FAST_MUL_EN).
REQ-036 out_ready low 5 cycles in DONE -> out_result/out_rd stable, in_ready=0; out_ready high -> IDLE, in_ready=1 next cycle.
REQ-037 kill in CALC cycle 10 with in_valid high -> no accept, no out_valid, IDLE next cycle; next op accepted the following cycle.
REQ-038 rst_n low in CALC cycle 5 -> outputs at reset values immediately; no out_valid after release.
